mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Arbiter bus: two requester ports plus the
// synchronous-RAM side and completion counters.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [7:0]    cnt0;
  logic [7:0]    cnt1;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  cnt0, cnt1
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output cnt0, cnt1
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of
// a synchronous RAM: grant, access, respond.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [7:0]    r_cnt0;
  logic [7:0]    r_cnt1;
  logic          w_win;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_done0;
  logic          w_done1;
  logic          w_en;
  logic          w_rd_resp;

  // Requester 1 wins when alone, or on a tie
  // when requester 0 was granted last.
  assign w_win = bus.req1 & (~bus.req0 | ~r_last);

  // Next state and per-state strobes.
  always_comb begin
    w_next  = r_state;
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    w_en    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          w_gnt0 = ~w_win;
          w_gnt1 = w_win;
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        w_en   = 1'b1;
        w_next = RESP;
      end
      RESP: begin
        w_done0 = ~r_owner;
        w_done1 = r_owner;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Latch the winner's request, capture read
  // data and count completions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      if (w_gnt0 | w_gnt1) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_we    <= w_win ? bus.we1 : bus.we0;
        r_addr  <= w_win ? bus.addr1 : bus.addr0;
        r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
      end
      if (w_rd_resp) r_rdata <= bus.mem_rdata;
      if (w_done0 && r_cnt0 != 8'hFF)
        r_cnt0 <= r_cnt0 + 8'd1;
      if (w_done1 && r_cnt1 != 8'hFF)
        r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  // Reset also masks the combinational strobes
  // so an aborted access leaves no trace.
  assign w_rd_resp = (r_state == RESP) & ~r_we;

  assign bus.gnt0      = rst_n & w_gnt0;
  assign bus.gnt1      = rst_n & w_gnt1;
  assign bus.done0     = rst_n & w_done0;
  assign bus.done1     = rst_n & w_done1;
  assign bus.mem_en    = rst_n & w_en;
  assign bus.mem_we    = rst_n & w_en & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rdata     = (rst_n & w_rd_resp) ?
                         bus.mem_rdata : r_rdata;
  assign bus.cnt0      = r_cnt0;
  assign bus.cnt1      = r_cnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a
// behavioural synchronous RAM.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we)
        mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.we0    = 1'b0;
    bus.we1    = 1'b0;
    bus.addr0  = '0;
    bus.addr1  = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
  endtask

  // One isolated transaction, checked cycle by
  // cycle: gnt at T, mem_en at T+1, done at T+2.
  task automatic xfer(input bit id, input bit we,
                      input logic [7:0] a,
                      input logic [7:0] d,
                      input logic [7:0] exp_rd,
                      input string tag);
    tick();
    if (id) begin
      bus.req1 = 1'b1; bus.we1 = we;
      bus.addr1 = a;   bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we;
      bus.addr0 = a;   bus.wdata0 = d;
    end
    #1;
    check({tag, ".gnt0"}, bus.gnt0, !id);
    check({tag, ".gnt1"}, bus.gnt1, id);
    check({tag, ".en_T"}, bus.mem_en, 0);
    tick();
    idle_in();
    #1;
    check({tag, ".en"}, bus.mem_en, 1);
    check({tag, ".we"}, bus.mem_we, we);
    check({tag, ".addr"}, bus.mem_addr, a);
    check({tag, ".wdata"}, bus.mem_wdata, d);
    check({tag, ".gnt_T1"},
          {bus.gnt0, bus.gnt1}, 0);
    tick();
    #1;
    check({tag, ".done0"}, bus.done0, !id);
    check({tag, ".done1"}, bus.done1, id);
    check({tag, ".rdata"}, bus.rdata, exp_rd);
    check({tag, ".en_T2"},
          {bus.mem_en, bus.mem_we}, 0);
  endtask

  int n_done;

  initial begin
    idle_in();
    rst_n = 1'b0;
    tick();
    tick();
    bus.req0 = 1'b1;
    #1;
    check("rst.gnt", {bus.gnt0, bus.gnt1}, 0);
    check("rst.done", {bus.done0, bus.done1}, 0);
    check("rst.en", {bus.mem_en, bus.mem_we}, 0);
    check("rst.addr", bus.mem_addr, 0);
    check("rst.wdata", bus.mem_wdata, 0);
    check("rst.rdata", bus.rdata, 0);
    check("rst.cnt0", bus.cnt0, 0);
    check("rst.cnt1", bus.cnt1, 0);
    idle_in();
    rst_n = 1'b1;

    xfer(1, 1, 8'h10, 8'hA5, 8'h00, "wr10");
    xfer(0, 0, 8'h10, 8'h00, 8'hA5, "rd10");
    xfer(1, 1, 8'hFF, 8'h3C, 8'hA5, "wrFF");
    xfer(0, 0, 8'hFF, 8'h00, 8'h3C, "rdFF");
    tick();
    #1;
    check("seq.cnt0", bus.cnt0, 2);
    check("seq.cnt1", bus.cnt1, 2);

    // Withdrawal while requester 0 is busy.
    bus.req0 = 1'b1; bus.addr0 = 8'h10;
    #1;
    check("wd.gnt0", bus.gnt0, 1);
    tick();
    idle_in();
    bus.req1 = 1'b1; bus.we1 = 1'b1;
    bus.addr1 = 8'h20; bus.wdata1 = 8'h99;
    #1;
    check("wd.gnt1_a", bus.gnt1, 0);
    tick();
    idle_in();
    #1;
    check("wd.gnt1_b", bus.gnt1, 0);
    check("wd.done0", bus.done0, 1);
    check("wd.rdata", bus.rdata, 8'hA5);
    tick();
    #1;
    check("wd.gnt_idle", {bus.gnt0, bus.gnt1}, 0);
    check("wd.cnt1", bus.cnt1, 2);
    check("wd.cnt0", bus.cnt0, 3);

    // Reset during the ACCESS cycle of a write.
    bus.req1 = 1'b1; bus.we1 = 1'b1;
    bus.addr1 = 8'h30; bus.wdata1 = 8'h77;
    #1;
    check("rma.gnt1", bus.gnt1, 1);
    tick();
    idle_in();
    rst_n = 1'b0;
    tick();
    #1;
    check("rma.done", {bus.done0, bus.done1}, 0);
    check("rma.en", {bus.mem_en, bus.mem_we}, 0);
    check("rma.addr", bus.mem_addr, 0);
    check("rma.wdata", bus.mem_wdata, 0);
    check("rma.rdata", bus.rdata, 0);
    check("rma.cnt0", bus.cnt0, 0);
    check("rma.cnt1", bus.cnt1, 0);

    // Contention straight out of reset.
    rst_n = 1'b1;
    bus.req0 = 1'b1; bus.addr0 = 8'h10;
    bus.req1 = 1'b1; bus.addr1 = 8'hFF;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) tick();
      #1;
      check($sformatf("ct%0d.gnt0", c),
            bus.gnt0, (c % 6) == 0);
      check($sformatf("ct%0d.gnt1", c),
            bus.gnt1, (c % 6) == 3);
      check($sformatf("ct%0d.both", c),
            bus.gnt0 & bus.gnt1, 0);
      check($sformatf("ct%0d.done0", c),
            bus.done0, (c % 6) == 2);
      check($sformatf("ct%0d.done1", c),
            bus.done1, (c % 6) == 5);
      if ((c % 6) == 2)
        check($sformatf("ct%0d.rd0", c),
              bus.rdata, 8'hA5);
      if ((c % 6) == 5)
        check($sformatf("ct%0d.rd1", c),
              bus.rdata, 8'h3C);
    end
    tick();
    idle_in();
    #1;
    check("ct.cnt0", bus.cnt0, 2);
    check("ct.cnt1", bus.cnt1, 2);

    // 300 back-to-back reads saturate cnt0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_done = 0;
    bus.req0 = 1'b1; bus.addr0 = 8'h10;
    for (int c = 0; c < 900; c++) begin
      #1;
      if (bus.done0) n_done++;
      if (c == 762)
        check("sat.cnt_fe", bus.cnt0, 8'hFE);
      if (c == 765)
        check("sat.cnt_ff", bus.cnt0, 8'hFF);
      tick();
    end
    idle_in();
    #1;
    check("sat.ndone", n_done, 300);
    check("sat.cnt0", bus.cnt0, 8'hFF);
    check("sat.cnt1", bus.cnt1, 0);
    tick();
    #1;
    check("sat.hold", bus.cnt0, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
